// File: rtl/addr_gen_unit.sv
// addr_gen_unit: expands a base vector register into its LMUL group, one address per clock
module addr_gen_unit #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2:0]            vlmul,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  idle
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0] last, count, grp_last;
  always_comb grp_last = vlmul[2] ? 3'd0 : 3'((4'd1 << vlmul[1:0]) - 4'd1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb state_nxt = state == IDLE ? (en ? BUSY : IDLE) : (count == last ? IDLE : BUSY);
  always_comb idle = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_out <= '0;
      base     <= '0;
      last     <= '0;
      count    <= '0;
    end else if (idle && en) begin
      addr_out <= addr_in;
      base     <= addr_in;
      last     <= grp_last;
      count    <= '0;
    end else if (!idle && count != last) begin
      count    <= count + 3'd1;
      addr_out <= base + ADDR_WIDTH'(count) + ADDR_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_addr_gen_unit.sv
// tb_addr_gen_unit: directed and random checks of addr_gen_unit against a queue-based model
module tb_addr_gen_unit;
  logic clk = 1'b0;
  logic rst, en;
  logic [2:0] vlmul;
  logic [4:0] addr_in, addr_out;
  logic idle;
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_last = 5'd0;
  int gsz[8] = '{1, 2, 4, 8, 1, 1, 1, 1};

  addr_gen_unit #(.ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .en(en), .vlmul(vlmul),
    .addr_in(addr_in), .addr_out(addr_out), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] v, input logic [4:0] a);
    rst = r; en = e; vlmul = v; addr_in = a;
    if (r) begin
      exp_q.delete();
      exp_last = 5'd0;
    end else if (exp_q.size() > 0) begin
      exp_last = exp_q.pop_front();
    end else if (e) begin
      for (int i = 0; i < gsz[v]; i++) exp_q.push_back(5'(int'(a) + i));
    end
    @(posedge clk);
    #1;
    check("idle", {4'd0, idle}, {4'd0, exp_q.size() == 0});
    check("addr_out", addr_out, exp_q.size() > 0 ? exp_q[0] : exp_last);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vlmul = 3'd0; addr_in = 5'd0;
    step(1, 1, 3'd3, 5'd9);
    check("reset_addr_const", addr_out, 5'd0);
    step(0, 0, 3'd0, 5'd0);
    step(0, 1, 3'b010, 5'd1);
    check("t1_first_const", addr_out, 5'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 3'd0, 5'd0);
    check("t1_hold_const", addr_out, 5'd4);
    step(0, 1, 3'b001, 5'd3);
    step(0, 1, 3'b011, 5'd20);
    check("t2_ignore_const", addr_out, 5'd4);
    step(0, 1, 3'b011, 5'd20);
    check("t2_gap_idle_const", {4'd0, idle}, 5'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 3'd0, 5'd0);
    step(0, 1, 3'b011, 5'd3);
    for (int i = 0; i < 10; i++) step(0, 0, 3'd0, 5'd0);
    check("t3_hold_const", addr_out, 5'd10);
    step(0, 1, 3'b010, 5'h1E);
    step(0, 0, 3'd0, 5'd0);
    step(0, 0, 3'd0, 5'd0);
    check("t4_wrap_const", addr_out, 5'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 5'd0);
    step(0, 1, 3'b101, 5'd7);
    check("t5_frac_const", addr_out, 5'd7);
    step(0, 0, 3'd0, 5'd0);
    step(0, 1, 3'b011, 5'd12);
    step(0, 0, 3'd0, 5'd0);
    step(1, 0, 3'd0, 5'd0);
    check("t6_reset_const", addr_out, 5'd0);
    step(0, 1, 3'b001, 5'd17);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 5'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 3'($urandom), 5'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
